// File: rtl/cla_carry_engine.sv
// rtl/cla_carry_engine.sv - multi-cycle carry-lookahead carry engine, one G-bit group per cycle
// Optional feature macro: CLA_OVF_EN adds a registered signed-overflow output ovf.
module cla_carry_engine #(
    parameter int N = 64,
    parameter int G = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic [N-1:0] p,
    output logic         cout
`ifdef CLA_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int NG = N / G;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [GW-1:0] LAST_GRP = GW'(NG - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (N % G != 0) begin : g_bad_width
        $error("cla_carry_engine: N must be a multiple of G");
    end

    logic [1:0]    state;
    logic [GW-1:0] grp;
    logic          cr;
    logic [N-1:0]  g;

    logic [G-1:0]  grp_p;
    logic [G-1:0]  grp_g;
    logic [G:0]    grp_c;
    int            base;

    // Carry chain of one group; bit G is the group carry-out.
    function automatic logic [G:0] group_carries(input logic [G-1:0] gp,
                                                 input logic [G-1:0] gg,
                                                 input logic         ci);
        logic [G:0] cc;
        cc[0] = ci;
        for (int k = 0; k < G; k++) begin
            cc[k+1] = gg[k] | (gp[k] & cc[k]);
        end
        return cc;
    endfunction

    always_comb begin
        base  = int'(grp) * G;
        grp_p = p[base +: G];
        grp_g = g[base +: G];
        grp_c = group_carries(grp_p, grp_g, cr);
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            grp   <= '0;
            cr    <= 1'b0;
            c     <= '0;
            p     <= '0;
            g     <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        p     <= a ^ b;
                        g     <= a & b;
                        cr    <= cin;
                        c     <= '0;
                        grp   <= '0;
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    c[base +: G] <= grp_c[G-1:0];
                    cr           <= grp_c[G];
                    if (grp == LAST_GRP) begin
                        cout  <= grp_c[G];
                        grp   <= '0;
                        state <= S_DONE;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CLA_OVF_EN
    // Overflow is the carry into the sign bit against the carry out of it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == S_CALC && grp == LAST_GRP) begin
            ovf <= grp_c[G-1] ^ grp_c[G];
        end
    end
`endif

endmodule

// File: tb/tb_cla_carry_engine.sv
// tb/tb_cla_carry_engine.sv - scoreboard bench for cla_carry_engine against an arithmetic model
module tb_cla_carry_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] c;
    logic [63:0] p;
    logic        cout;
`ifdef CLA_OVF_EN
    logic        ovf;
`endif

    cla_carry_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .p(p), .cout(cout)
`ifdef CLA_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [64:0] sum;
        logic [63:0] px;
        logic        sov;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   rcv = 0;
    bit   done_flag = 1'b0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Signed overflow from operand signs and the sign of the true sum.
    function automatic exp_t model(input logic [63:0] ma, input logic [63:0] mb, input logic mc);
        exp_t e;
        logic [63:0] s;
        e.sum = {1'b0, ma} + {1'b0, mb} + {64'd0, mc};
        e.px  = ma ^ mb;
        s     = e.sum[63:0];
        e.sov = (ma[63] == mb[63]) && (s[63] != ma[63]);
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        chk({tag, "_sum"}, {cout, c ^ p}, e.sum);
        chk({tag, "_p"}, {1'b0, p}, {1'b0, e.px});
`ifdef CLA_OVF_EN
        chk({tag, "_ovf"}, {64'd0, ovf}, {64'd0, e.sov});
`endif
    endtask

    task automatic run_op(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                          input logic tc, input int hold);
        exp_t e;
        int n;
        logic [63:0] sc, sp;
        logic scout;
        e = model(ta, tb, tc);
        @(posedge clk); #1;
        chk({tag, "_in_ready"}, {64'd0, in_ready}, 65'd1);
        a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'b1;
        chk({tag, "_busy"}, {63'd0, in_ready, out_valid}, 65'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 65'(n), 65'd8);
        check_result(tag, e);
        for (int i = 0; i < hold; i++) begin
            sc = c; sp = p; scout = cout;
            in_valid = 1'(i % 2 == 0);
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            @(posedge clk); #1;
            chk({tag, "_hold_hs"}, {63'd0, out_valid, in_ready}, 65'b10);
            chk({tag, "_hold_c"}, {1'b0, c}, {1'b0, sc});
            chk({tag, "_hold_pcout"}, {cout, p}, {scout, sp});
        end
        in_valid = 1'b0;
        if (hold > 0) check_result({tag, "_after_hold"}, e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_release"}, {63'd0, in_ready, out_valid}, 65'b10);
        out_ready = 1'b0;
    endtask

    initial begin
        exp_t e;
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hs", {63'd0, in_ready, out_valid}, 65'b10);
        chk("reset_c", {1'b0, c}, 65'd0);
        chk("reset_pcout", {cout, p}, 65'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        chk("ripple_c", {1'b0, c}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        run_op("fullprop", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1, 0);
        chk("fullprop_c", {1'b0, c}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        run_op("zero", 64'd0, 64'd0, 1'b0, 0);
        run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        chk("sovf_c63", {64'd0, c[63]}, 65'd1);
        run_op("backpress", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 5);

        // Abort while group 3 is pending: accept edge, then three CALC edges.
        @(posedge clk); #1;
        a = 64'hFFFF_0000_FFFF_0000; b = 64'h0F0F_0F0F_0F0F_0F0F; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_hs", {63'd0, in_ready, out_valid}, 65'b10);
        chk("midrst_c", {1'b0, c}, 65'd0);
        chk("midrst_pcout", {cout, p}, 65'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("postrst", 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 1'b0, 0);

        fork
            begin : driver
                int issued = 0;
                while (!done_flag) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                    if (in_ready) begin
                        if (issued < 1000 && $urandom_range(0, 3) != 0) begin
                            a = {$urandom, $urandom};
                            b = {$urandom, $urandom};
                            cin = 1'($urandom_range(0, 1));
                            in_valid = 1'b1;
                            exp_q.push_back(model(a, b, cin));
                            issued++;
                        end else begin
                            in_valid = 1'b0;
                        end
                    end else begin
                        a = {$urandom, $urandom};
                        in_valid = 1'($urandom_range(0, 1));
                    end
                end
                in_valid = 1'b0;
                out_ready = 1'b0;
            end
            begin : monitor
                cyc = 0;
                while (rcv < 1000 && cyc < 60000) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("rand_unexpected", 65'd1, 65'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check_result("rand", e);
                        end
                        rcv++;
                    end
                end
                chk("rand_count", 65'(rcv), 65'd1000);
                done_flag = 1'b1;
            end
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cla_carry_engine.md
# cla_carry_engine

Multi-cycle carry-lookahead carry engine for the N-bit CLA adder datapath. It registers operands a, b and carry-in, and forms bitwise propagate p = a ^ b and generate g = a & b. It then resolves the per-bit carry vector c one G-bit lookahead group per cycle. Its outputs are c[N-1:0] and p[N-1:0], the inputs of the N-bit sum generator (s = c ^ p). Operand and result transfer use valid/ready handshakes.

## Interface
- N, 64: operand width; must be a multiple of G, otherwise elaboration fails with `$error`.
- G, 8: lookahead group width; NG = N/G groups.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand transfer request.
- in_ready  output  1  engine can accept operands; high only in IDLE.
- a, b  input  N  operands.
- cin  input  1  carry into bit 0.
- out_valid  output  1  c, p, cout valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- c  output  N  carry into each bit; c[0] = cin.
- p  output  N  propagate vector a ^ b.
- cout  output  1  carry out of bit N-1.

## Operation
- States: IDLE, CALC, DONE. Group index grp is ceil(log2(NG)) bits wide, range 0..NG-1.
- IDLE: in_ready = 1. When in_valid is high at an edge:
  - register p = a ^ b, g = a & b, and carry register cr = cin;
  - clear c; set grp = 0; go to CALC.
- CALC: each edge handles group grp, bits [grp*G +: G]:
  - lookahead inside the group: c[k+1] = g[k] | p[k]&c[k], with the group's first carry equal to cr;
  - write the G carries into c[grp*G +: G];
  - set cr to the group carry-out and increment grp.
  - When grp = NG-1, also load cout = group carry-out and go to DONE.
- DONE: out_valid = 1; c, p and cout stay stable. When out_ready is high at an edge, go to IDLE. out_valid and the outputs hold indefinitely while out_ready is low.
- in_valid outside IDLE is ignored; no operand capture.
- a, b and cin are sampled only at the accept edge; later changes do not affect the result.
- Arithmetic is unsigned and modulo 2^N; {cout, s} equals a + b + cin.

## Timing
- Reset (async, while rst is high): state = IDLE, grp = 0, cr = 0, c = 0, p = 0, g = 0, cout = 0. Resulting outputs: in_ready = 1, out_valid = 0.
- Reset mid-CALC or mid-DONE aborts the operation immediately; no result is ever presented.
- Latency: with the accept at edge k, out_valid rises after edge k+NG (8 cycles for the default parameters).
- Minimum initiation interval: NG+2 cycles when out_ready is held high (accept, NG CALC edges, DONE→IDLE edge).
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Outputs c, p and cout are driven straight from registers.
- In IDLE and CALC, c and p show partial or previous values; they are meaningful only while out_valid is high.

## Configuration
- CLA_OVF_EN defined:
  - adds the output port ovf (output, 1 bit) = c[N-1] ^ cout, the signed two's-complement overflow;
  - ovf is registered at the last CALC edge, valid with out_valid, and reset to 0.
- CLA_OVF_EN undefined: no ovf port and no ovf register; all other behaviour is identical.

## Test plan
(Defaults N=64, G=8.)
- Carry ripple: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0.
  - c=FFFF_FFFF_FFFF_FFFE, p=FFFF_FFFF_FFFF_FFFE, cout=1, so c^p = 0.
  - out_valid rises 8 edges after the accept.
- Full propagate: a=AAAA_AAAA_AAAA_AAAA, b=5555_5555_5555_5555, cin=1.
  - p=FFFF_FFFF_FFFF_FFFF, c=FFFF_FFFF_FFFF_FFFF, cout=1.
  - With CLA_OVF_EN: ovf=0.
- Zero and signed overflow cases:
  - a=0, b=0, cin=0 gives c=0, p=0, cout=0.
  - a=7FFF_FFFF_FFFF_FFFF, b=1, cin=0 gives cout=0, c[63]=1; with CLA_OVF_EN, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid stays 1, in_ready stays 0, c/p/cout are unchanged.
  - in_valid pulses during this window are not captured.
  - out_ready=1 gives IDLE on the next edge.
- Reset mid-operation: assert rst while grp=3.
  - Immediately (before the next edge): in_ready=1, out_valid=0, c=p=0, cout=0.
  - After release, a fresh operand set completes with the correct result.
- Randomized scoreboard of 1000 operations with random in_valid/out_ready gaps: checks {cout, c^p} == a+b+cin and p == a^b.
